// File: rtl/rsp_frame_tx.sv
// Purpose: serialises one response frame (SOF, LEN, CMD, payload, EOF) to a UART byte interface.
// Latency: first byte valid one cycle after start; each payload byte costs a FETCH plus a PLD cycle.
// Backpressure: tx_valid/tx_ready handshake; the FSM and tx_data hold while tx_ready is low.
module rsp_frame_tx #(
    parameter int          PLD_MAX  = 16,
    parameter logic [7:0]  SOF_BYTE = 8'hFE,
    parameter logic [7:0]  EOF_BYTE = 8'hEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [4:0] pld_len,
    output logic [3:0] pld_rd_addr,
    input  logic [7:0] pld_rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_LEN,
        S_CMD,
        S_FETCH,
        S_PLD,
        S_EOF,
        S_DONE
    } state_t;

    // PLD_MAX is expected to be 1..16, so it always fits the 5-bit length field.
    localparam logic [4:0] PLD_MAX_L = 5'(PLD_MAX);

    state_t     state_q;
    logic [7:0] cmd_q;
    logic [4:0] n_q;
    logic [4:0] idx_q;
    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] addr_q;

    logic [4:0] n_d;
    logic [4:0] idx_inc;
    logic       xfer;

    // Effective payload length is the requested length clipped to the buffer size.
    always_comb begin
        n_d = (pld_len > PLD_MAX_L) ? PLD_MAX_L : pld_len;
    end

    assign idx_inc = idx_q + 5'd1;
    assign xfer    = tx_valid_q & tx_ready;

    // Frame sequencer; every output is registered and set up for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= 8'd0;
            n_q        <= 5'd0;
            idx_q      <= 5'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cmd_q      <= cmd;
                        n_q        <= n_d;
                        idx_q      <= 5'd0;
                        state_q    <= S_SOF;
                        tx_data_q  <= SOF_BYTE;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_SOF: begin
                    if (xfer) begin
                        state_q   <= S_LEN;
                        tx_data_q <= {3'b000, n_q} + 8'd1;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        state_q   <= S_CMD;
                        tx_data_q <= cmd_q;
                    end
                end
                S_CMD: begin
                    if (xfer) begin
                        if (n_q != 5'd0) begin
                            state_q    <= S_FETCH;
                            tx_valid_q <= 1'b0;
                            addr_q     <= idx_q[3:0];
                        end else begin
                            state_q   <= S_EOF;
                            tx_data_q <= EOF_BYTE;
                        end
                    end
                end
                S_FETCH: begin
                    // Buffer data for addr_q is valid during this cycle; capture it as the next byte.
                    state_q    <= S_PLD;
                    tx_data_q  <= pld_rd_data;
                    tx_valid_q <= 1'b1;
                    addr_q     <= 4'd0;
                end
                S_PLD: begin
                    if (xfer) begin
                        idx_q <= idx_inc;
                        if (idx_inc < n_q) begin
                            state_q    <= S_FETCH;
                            tx_valid_q <= 1'b0;
                            addr_q     <= idx_inc[3:0];
                        end else begin
                            state_q   <= S_EOF;
                            tx_data_q <= EOF_BYTE;
                        end
                    end
                end
                S_EOF: begin
                    if (xfer) begin
                        state_q    <= S_DONE;
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    addr_q     <= 4'd0;
                end
            endcase
        end
    end

    assign pld_rd_addr = addr_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
